// File: rtl/fir_coef_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fir_coef_loader_if                                     |
// | Description : SPI-side coefficient strobes/registers and RAM-side    |
// |               write port of the FIR coefficient loader.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface fir_coef_loader_if #(
    parameter int FILT_W = 2
);
    // Control / SPI register side
    logic                coef_wr_stb;
    logic [7:0]          coef_lsb;
    logic [7:0]          coef_msb;
    logic [7:0]          filter_select;
    logic [7:0]          taps_per_filter;
    logic                addr_rst;
    logic                swap_req;
    logic                sample_stb;
    logic                err_clr;
    // Coefficient RAM / status side
    logic                coef_we;
    logic [FILT_W+8:0]   coef_waddr;
    logic [15:0]         coef_wdata;
    logic                active_bank;
    logic [7:0]          tap_ptr;
    logic                swap_pending;
    logic                filter_done;
    logic                load_err;

    // Controller side: drives the strobes, observes the RAM port and status
    modport master (
        output coef_wr_stb, coef_lsb, coef_msb, filter_select, taps_per_filter,
               addr_rst, swap_req, sample_stb, err_clr,
        input  coef_we, coef_waddr, coef_wdata, active_bank, tap_ptr,
               swap_pending, filter_done, load_err
    );

    // Loader side
    modport slave (
        input  coef_wr_stb, coef_lsb, coef_msb, filter_select, taps_per_filter,
               addr_rst, swap_req, sample_stb, err_clr,
        output coef_we, coef_waddr, coef_wdata, active_bank, tap_ptr,
               swap_pending, filter_done, load_err
    );
endinterface
`default_nettype wire

// File: rtl/fir_coef_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fir_coef_loader                                        |
// | Description : Loads 16-bit FIR coefficients into the shadow bank of  |
// |               a double-buffered coefficient RAM and swaps banks at   |
// |               an audio frame boundary.                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fir_coef_loader #(
    parameter int NUM_FILTERS = 4,
    parameter int FILT_W      = 2
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    fir_coef_loader_if.slave bus
);

    localparam logic       c_ST_LOAD      = 1'b0;
    localparam logic       c_ST_SWAP_PEND = 1'b1;
    localparam logic [8:0] c_NUM_FILT     = 9'(NUM_FILTERS);

    logic              r_state;
    logic              r_active_bank;
    logic              r_coef_we;
    logic [FILT_W+8:0] r_coef_waddr;
    logic [15:0]       r_coef_wdata;
    logic [7:0]        r_tap_ptr;
    logic [7:0]        r_filt_prev;
    logic              r_filter_done;
    logic              r_load_err;

    logic              w_wr_valid;
    logic              w_wr_bad;
    logic              w_ptr_clr;
    logic              w_swap_done;
    logic              w_wrap;
    logic [7:0]        w_tap_eff;
    logic [7:0]        w_taps_m1;

    // A pointer clear (explicit or by filter change) applies to a write in
    // the same cycle, so the write lands on tap 0.
    assign w_ptr_clr   = bus.addr_rst || (bus.filter_select != r_filt_prev);
    assign w_tap_eff   = w_ptr_clr ? 8'd0 : r_tap_ptr;
    assign w_taps_m1   = bus.taps_per_filter - 8'd1;
    assign w_wrap      = (w_tap_eff >= w_taps_m1);
    assign w_wr_valid  = bus.coef_wr_stb && (r_state == c_ST_LOAD)
                       && ({1'b0, bus.filter_select} < c_NUM_FILT)
                       && (bus.taps_per_filter != 8'd0);
    assign w_wr_bad    = bus.coef_wr_stb && !w_wr_valid;
    assign w_swap_done = (r_state == c_ST_SWAP_PEND) && bus.sample_stb;

    // Bank-swap FSM: a request is only honoured at a later frame boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_ST_LOAD;
            r_active_bank <= 1'b0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (bus.swap_req) r_state <= c_ST_SWAP_PEND;
                end
                c_ST_SWAP_PEND: begin
                    if (bus.sample_stb) begin
                        r_state       <= c_ST_LOAD;
                        r_active_bank <= ~r_active_bank;
                    end
                end
                default: r_state <= c_ST_LOAD;
            endcase
        end
    end

    // Registered RAM write port; always targets the bank the FIR is not reading
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_coef_we     <= 1'b0;
            r_coef_waddr  <= '0;
            r_coef_wdata  <= '0;
            r_filter_done <= 1'b0;
        end else begin
            r_coef_we     <= w_wr_valid;
            r_filter_done <= w_wr_valid && w_wrap;
            if (w_wr_valid) begin
                r_coef_waddr <= {~r_active_bank, bus.filter_select[FILT_W-1:0], w_tap_eff};
                r_coef_wdata <= {bus.coef_msb, bus.coef_lsb};
            end
        end
    end

    // Tap pointer: advances per valid write, wraps at the filter length
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tap_ptr <= 8'd0;
        end else if (w_swap_done) begin
            r_tap_ptr <= 8'd0;
        end else if (w_wr_valid) begin
            r_tap_ptr <= w_wrap ? 8'd0 : w_tap_eff + 8'd1;
        end else if (w_ptr_clr) begin
            r_tap_ptr <= 8'd0;
        end
    end

    // Remember last cycle's filter index to detect a change of target
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt_prev <= 8'd0;
        end else begin
            r_filt_prev <= bus.filter_select;
        end
    end

    // Sticky error flag; a new error wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load_err <= 1'b0;
        end else if (w_wr_bad) begin
            r_load_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_load_err <= 1'b0;
        end
    end

    assign bus.coef_we      = r_coef_we;
    assign bus.coef_waddr   = r_coef_waddr;
    assign bus.coef_wdata   = r_coef_wdata;
    assign bus.active_bank  = r_active_bank;
    assign bus.tap_ptr      = r_tap_ptr;
    assign bus.swap_pending = (r_state == c_ST_SWAP_PEND);
    assign bus.filter_done  = r_filter_done;
    assign bus.load_err     = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fir_coef_loader                                     |
// | Description : Self-checking bench for fir_coef_loader: behavioural   |
// |               model compared every cycle plus directed literals.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fir_coef_loader;

    localparam int c_NF = 4;
    localparam int c_FW = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    fir_coef_loader_if #(.FILT_W(c_FW)) bus ();

    fir_coef_loader #(.NUM_FILTERS(c_NF), .FILT_W(c_FW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int   m_tap  = 0;
    int   m_prev = 0;
    bit   m_bank = 0;
    bit   m_pend = 0;
    bit   m_err  = 0;
    bit   e_we   = 0;
    bit   e_done = 0;
    int   e_addr = 0;
    int   e_data = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_tap = 0; m_prev = 0; m_bank = 0; m_pend = 0; m_err = 0;
            e_we = 0; e_done = 0; e_addr = 0; e_data = 0;
        end else begin
            int  t;
            int  fs;
            int  taps;
            bit  clr;
            bit  bad;
            fs   = int'(bus.filter_select);
            taps = int'(bus.taps_per_filter);
            clr  = bus.addr_rst || (fs != m_prev);
            bad  = 0;
            e_we = 0; e_done = 0;
            if (bus.coef_wr_stb && !m_pend && fs < c_NF && taps != 0) begin
                t      = clr ? 0 : m_tap;
                e_we   = 1;
                e_addr = (m_bank ? 0 : 1) * 1024 + fs * 256 + t;
                e_data = int'(bus.coef_msb) * 256 + int'(bus.coef_lsb);
                if (t + 1 >= taps) begin
                    m_tap = 0; e_done = 1;
                end else begin
                    m_tap = t + 1;
                end
            end else begin
                bad = bus.coef_wr_stb;
                if (clr) m_tap = 0;
            end
            if (bad) m_err = 1;
            else if (bus.err_clr) m_err = 0;
            if (m_pend && bus.sample_stb) begin
                m_bank = !m_bank; m_pend = 0; m_tap = 0;
            end else if (!m_pend && bus.swap_req) begin
                m_pend = 1;
            end
            m_prev = fs;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle outside reset
    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_we", int'(bus.coef_we), int'(e_we));
            if (e_we) begin
                chk("m_addr", int'(bus.coef_waddr), e_addr);
                chk("m_data", int'(bus.coef_wdata), e_data);
            end
            chk("m_bank", int'(bus.active_bank), int'(m_bank));
            chk("m_tap",  int'(bus.tap_ptr), m_tap);
            chk("m_pend", int'(bus.swap_pending), int'(m_pend));
            chk("m_done", int'(bus.filter_done), int'(e_done));
            chk("m_err",  int'(bus.load_err), int'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] msb, input logic [7:0] lsb);
        bus.coef_msb    = msb;
        bus.coef_lsb    = lsb;
        bus.coef_wr_stb = 1'b1;
        tick();
        bus.coef_wr_stb = 1'b0;
    endtask

    task automatic pulse_err_clr();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    initial begin
        bus.coef_wr_stb = 0; bus.coef_lsb = 0; bus.coef_msb = 0;
        bus.filter_select = 0; bus.taps_per_filter = 8'd3;
        bus.addr_rst = 0; bus.swap_req = 0; bus.sample_stb = 0; bus.err_clr = 0;

        repeat (3) tick();
        chk("rst_we",   int'(bus.coef_we), 0);
        chk("rst_addr", int'(bus.coef_waddr), 0);
        chk("rst_data", int'(bus.coef_wdata), 0);
        chk("rst_tap",  int'(bus.tap_ptr), 0);
        chk("rst_bank", int'(bus.active_bank), 0);
        chk("rst_pend", int'(bus.swap_pending), 0);
        chk("rst_err",  int'(bus.load_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Three back-to-back writes to filter 2, bank 1 (shadow)
        bus.filter_select = 8'd2;
        tick();
        strobe(8'h12, 8'h34);
        chk("w1_addr", int'(bus.coef_waddr), 'h600);
        chk("w1_data", int'(bus.coef_wdata), 'h1234);
        chk("w1_tap",  int'(bus.tap_ptr), 1);
        bus.coef_msb = 8'h56; bus.coef_lsb = 8'h78; bus.coef_wr_stb = 1'b1;
        tick();
        chk("w2_addr", int'(bus.coef_waddr), 'h601);
        bus.coef_msb = 8'h9A; bus.coef_lsb = 8'hBC;
        tick();
        bus.coef_wr_stb = 1'b0;
        chk("w3_addr", int'(bus.coef_waddr), 'h602);
        chk("w3_data", int'(bus.coef_wdata), 'h9ABC);
        chk("w3_done", int'(bus.filter_done), 1);
        chk("w3_tap",  int'(bus.tap_ptr), 0);

        // Out-of-range filter, then clear; then clear racing a new error
        bus.filter_select = 8'd4;
        tick();
        strobe(8'h01, 8'h02);
        chk("bad_we",  int'(bus.coef_we), 0);
        chk("bad_err", int'(bus.load_err), 1);
        pulse_err_clr();
        chk("clr_err", int'(bus.load_err), 0);
        bus.err_clr = 1'b1;
        strobe(8'h01, 8'h02);
        bus.err_clr = 1'b0;
        chk("race_err", int'(bus.load_err), 1);
        pulse_err_clr();

        // Swap sequence
        bus.filter_select = 8'd0;
        tick();
        strobe(8'hAA, 8'h55);
        chk("pre_addr", int'(bus.coef_waddr), 'h400);
        bus.swap_req = 1'b1; bus.sample_stb = 1'b1;
        tick();
        bus.swap_req = 1'b0; bus.sample_stb = 1'b0;
        chk("sw_pend", int'(bus.swap_pending), 1);
        chk("sw_bank0", int'(bus.active_bank), 0);
        tick();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        chk("sw_req2_err", int'(bus.load_err), 0);
        strobe(8'h77, 8'h77);
        chk("pend_we",  int'(bus.coef_we), 0);
        chk("pend_err", int'(bus.load_err), 1);
        chk("pend_tap", int'(bus.tap_ptr), 1);
        pulse_err_clr();
        bus.sample_stb = 1'b1;
        tick();
        bus.sample_stb = 1'b0;
        chk("sw_bank1", int'(bus.active_bank), 1);
        chk("sw_pend0", int'(bus.swap_pending), 0);
        chk("sw_tap",   int'(bus.tap_ptr), 0);
        strobe(8'h00, 8'h01);
        chk("b0_addr", int'(bus.coef_waddr), 'h000);

        // Walk pointer to 7, then pointer reset coincident with a write
        bus.taps_per_filter = 8'd10;
        for (int i = 0; i < 6; i++) strobe(8'(i), 8'h00);
        chk("tap7", int'(bus.tap_ptr), 7);
        bus.addr_rst = 1'b1;
        strobe(8'hBE, 8'hEF);
        bus.addr_rst = 1'b0;
        chk("ar_addr", int'(bus.coef_waddr), 'h000);
        chk("ar_data", int'(bus.coef_wdata), 'hBEEF);
        chk("ar_tap",  int'(bus.tap_ptr), 1);

        // Shrinking the filter length mid-load wraps on the next write
        bus.taps_per_filter = 8'd2;
        strobe(8'h22, 8'h33);
        chk("shr_addr", int'(bus.coef_waddr), 'h001);
        chk("shr_done", int'(bus.filter_done), 1);

        // Zero taps is an error
        bus.taps_per_filter = 8'd0;
        strobe(8'h44, 8'h55);
        chk("z_we",  int'(bus.coef_we), 0);
        chk("z_err", int'(bus.load_err), 1);
        pulse_err_clr();
        bus.taps_per_filter = 8'd2;

        // Reset while a write is on the RAM port
        strobe(8'h11, 8'h22);
        chk("pr_we", int'(bus.coef_we), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_we",   int'(bus.coef_we), 0);
        chk("ar_wadr", int'(bus.coef_waddr), 0);
        chk("ar_wdat", int'(bus.coef_wdata), 0);
        chk("ar_bank", int'(bus.active_bank), 0);
        chk("ar_tp",   int'(bus.tap_ptr), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        strobe(8'h66, 8'h77);
        chk("post_addr", int'(bus.coef_waddr), 'h400);
        chk("post_tap",  int'(bus.tap_ptr), 1);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
